mem_write_back_latch: RTL and testbench
=======================================

// Module: mem_write_back_latch
// PURPOSE
//  MEM/WB stage of the 5-stage pipeline. Issues the data-memory access for the
//  instruction leaving EX/MEM, holds the result until the pipeline advances, and
//  drives the write-back inputs consumed by decode: regWr, regDst, regSel,
//  dmemload, nPC, ALUOut, plus the selected write data.
//  Owns the dhit/ihit conflict: a captured dmemload survives pipeline freezes.
// PARAMETERS
//  DATA_W  32  datapath width; must equal WORD_W
//  REG_AW   5  register-index width
// PORTS
//  CLK           in   1       clock, rising edge
//  RST           in   1       synchronous active-high reset
//  en            in   1       pipeline advance (ihit && !upstream stall)
//  flush         in   1       insert bubble into WB latch
//  in_regWr      in   1       EX/MEM: register write enable
//  in_regDst     in   REG_AW  EX/MEM: destination register
//  in_regSel     in   regsel_t  EX/MEM: write-data source
//  in_dREN       in   1       EX/MEM: load
//  in_dWEN       in   1       EX/MEM: store
//  in_ALUOut     in   DATA_W  EX/MEM: ALU result / memory address
//  in_rdat2      in   DATA_W  EX/MEM: store data
//  in_nPC        in   DATA_W  EX/MEM: PC+4
//  dhit          in   1       data cache hit
//  dmemload      in   DATA_W  data cache read data
//  dmemREN       out  1       cache read request
//  dmemWEN       out  1       cache write request
//  dmemaddr      out  DATA_W  = in_ALUOut
//  dmemstore     out  DATA_W  = in_rdat2
//  mem_stall     out  1       freeze IF..MEM this cycle
//  regWr regDst regSel dmemload_q nPC ALUOut   out  WB latch fields
//  wdat          out  DATA_W  regSel mux: SEL_ALU->ALUOut, SEL_MEM->dmemload_q, SEL_NPC->nPC
// BEHAVIOUR
//  - Reset: all latch fields 0, regWr=0, state IDLE, dmemREN=dmemWEN=0, mem_stall=0.
//  - FSM IDLE/WAIT/DONE. Non-memory op: IDLE, no stall; latch loads on en, 1-cycle latency.
//  - IDLE with in_dREN|in_dWEN: dmemREN/WEN asserted combinationally from inputs.
//    dhit && en -> latch loads (dmemload captured), stay IDLE, no stall that cycle.
//    dhit && !en -> capture dmemload into hold reg, go DONE. !dhit -> go WAIT, mem_stall=1.
//  - WAIT: request held, mem_stall=1; dhit -> same split as IDLE (en ? latch+IDLE : DONE).
//  - DONE: requests deasserted (no re-issue, store never repeated), mem_stall=0;
//    on en latch loads from hold reg, -> IDLE.
//  - dREN and dWEN both set: illegal; treat as store, no load data captured.
//  - flush && en: latch loads bubble (regWr=0, others 0); an outstanding access
//    (WAIT) still completes, result discarded. flush && !en: no effect.
//  - RST mid-WAIT: requests drop next cycle, state IDLE; cache must tolerate abort.
//  - regDst==0 with regWr=1 passes through unchanged; register file ignores r0.
//  - wdat is combinational from latch; undefined regSel -> ALUOut.
// CONFIGURATION
//  MEM_WB_FWD_EN defined: extra outputs fwd_valid (=regWr && regDst!=0), fwd_reg
//  (=regDst), fwd_data (=wdat) for the EX forwarding unit; also a registered
//  fwd_mem_* set from the MEM side valid when a load completes in DONE.
//  Undefined: ports absent; hazard unit must stall on RAW against MEM/WB.
// STRUCTURE
//  cpu_types_pkg: regsel_t (SEL_ALU/SEL_MEM/SEL_NPC), regbits_t, word_t,
//  new memwb_state_t {IDLE,WAIT,DONE}, memwb_t struct of latch fields.
//  Sub-module: mem_access_fsm (state, hold reg, dmemREN/WEN, mem_stall);
//  top holds latch register and wdat mux.
// TESTING
//  1 ALU op in_ALUOut=0x1234, regDst=5, SEL_ALU, en=1 -> next cycle regWr=1, wdat=0x1234, no stall.
//  2 load addr 0x80, dhit after 3 cycles, dmemload=0xDEADBEEF -> mem_stall 3 cycles, then wdat=0xDEADBEEF.
//  3 load with dhit while en=0 for 2 cycles -> DONE, dmemREN=0, on en latch=captured value even if dmemload bus changed.
//  4 store 0xCAFE to 0x40, dhit with en=0 -> exactly one dmemWEN-hit cycle, no repeat in DONE.
//  5 flush&&en during ALU op regWr=1 -> latch regWr=0; flush&&!en -> latch unchanged.
//  6 RST asserted in WAIT -> next cycle dmemREN=0, regWr=0, mem_stall=0; with FWD_EN, fwd_valid=0 for regDst=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types for the MEM/WB stage
// Provides word/register types, the write-data source select, the
// MEM/WB access state encoding and the WB latch record.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W = 5;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0] regbits_t;
  typedef enum logic [1:0] {SEL_ALU = 2'd0, SEL_MEM = 2'd1, SEL_NPC = 2'd2} regsel_t;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} memwb_state_t;
  typedef struct packed {
    logic regWr;
    regbits_t regDst;
    regsel_t regSel;
    word_t dmemload;
    word_t nPC;
    word_t ALUOut;
  } memwb_t;
endpackage

// File: rtl/mem_write_back_latch_if.sv
// mem_write_back_latch_if: EX/MEM inputs, data-cache handshake and WB latch outputs
// slave  : the MEM/WB stage (consumes EX/MEM + cache, drives requests + WB fields)
// master : the surrounding pipeline/cache (drives EX/MEM + cache, reads WB fields)
// MEM_WB_FWD_EN adds the forwarding outputs fwd_* and fwd_mem_*.
interface mem_write_back_latch_if;
  import cpu_types_pkg::*;
  logic en, flush;
  logic in_regWr, in_dREN, in_dWEN;
  regbits_t in_regDst;
  regsel_t in_regSel;
  word_t in_ALUOut, in_rdat2, in_nPC;
  logic dhit;
  word_t dmemload;
  logic dmemREN, dmemWEN, mem_stall;
  word_t dmemaddr, dmemstore;
  logic regWr;
  regbits_t regDst;
  regsel_t regSel;
  word_t dmemload_q, nPC, ALUOut, wdat;
`ifdef MEM_WB_FWD_EN
  logic fwd_valid, fwd_mem_valid;
  regbits_t fwd_reg, fwd_mem_reg;
  word_t fwd_data, fwd_mem_data;
`endif
  modport slave (
    input en, flush, in_regWr, in_dREN, in_dWEN, in_regDst, in_regSel,
          in_ALUOut, in_rdat2, in_nPC, dhit, dmemload,
    output dmemREN, dmemWEN, mem_stall, dmemaddr, dmemstore,
           regWr, regDst, regSel, dmemload_q, nPC, ALUOut, wdat
`ifdef MEM_WB_FWD_EN
    , output fwd_valid, fwd_reg, fwd_data, fwd_mem_valid, fwd_mem_reg, fwd_mem_data
`endif
  );
  modport master (
    output en, flush, in_regWr, in_dREN, in_dWEN, in_regDst, in_regSel,
           in_ALUOut, in_rdat2, in_nPC, dhit, dmemload,
    input dmemREN, dmemWEN, mem_stall, dmemaddr, dmemstore,
          regWr, regDst, regSel, dmemload_q, nPC, ALUOut, wdat
`ifdef MEM_WB_FWD_EN
    , input fwd_valid, fwd_reg, fwd_data, fwd_mem_valid, fwd_mem_reg, fwd_mem_data
`endif
  );
endinterface

// File: rtl/mem_write_back_latch_access_fsm.sv
// mem_access_fsm: data-cache access sequencing for the MEM/WB stage
// Ports: CLK/RST; en (pipeline advance); dREN/dWEN/dhit/dmemload from EX/MEM and
// cache; dmemREN/dmemWEN requests, mem_stall, memData (load data for the latch).
// MEM_WB_FWD_EN adds regWr/regDst inputs and registered fwd_mem_* outputs.
module mem_access_fsm
  import cpu_types_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic dREN,
  input  logic dWEN,
  input  logic dhit,
  input  word_t dmemload,
  output logic dmemREN,
  output logic dmemWEN,
  output logic mem_stall,
  output word_t memData
`ifdef MEM_WB_FWD_EN
  ,
  input  logic regWr,
  input  regbits_t regDst,
  output logic fwd_mem_valid,
  output regbits_t fwd_mem_reg,
  output word_t fwd_mem_data
`endif
);
  memwb_state_t state, nextState;
  word_t holdReg;
  logic isLoad, access, busy, hitFrozen;
  // both enables set is illegal: it behaves as a store and captures no data
  assign isLoad = dREN && !dWEN;
  assign access = dREN || dWEN;
  // DONE keeps the finished access quiet so a store is never repeated
  assign busy = (state != DONE) && access;
  assign hitFrozen = busy && dhit && !en;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      holdReg <= '0;
    end else begin
      state <= nextState;
      if (hitFrozen) holdReg <= isLoad ? dmemload : '0;
    end
  end
  always_comb begin
    nextState = state == DONE ? (en ? IDLE : DONE)
              : !access ? IDLE
              : dhit ? (en ? IDLE : DONE)
              : WAIT;
  end
  // requests are gated by RST so an aborted access drops immediately
  always_comb begin
    dmemREN = !RST && busy && isLoad;
    dmemWEN = !RST && busy && dWEN;
    mem_stall = !RST && busy && !dhit;
    memData = state == DONE ? holdReg : dmemload;
  end
`ifdef MEM_WB_FWD_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      fwd_mem_valid <= 1'b0;
      fwd_mem_reg <= '0;
      fwd_mem_data <= '0;
    end else if (hitFrozen) begin
      fwd_mem_valid <= isLoad && regWr && regDst != '0;
      fwd_mem_reg <= regDst;
      fwd_mem_data <= dmemload;
    end else if (state == DONE && en) begin
      fwd_mem_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: rtl/mem_write_back_latch.sv
// mem_write_back_latch: MEM/WB pipeline stage (cache access + write-back latch)
// Ports: CLK, RST (sync active-high); bus (mem_write_back_latch_if.slave) carrying
// en/flush, EX/MEM fields, cache handshake, WB latch fields and wdat.
// Optional feature macro: MEM_WB_FWD_EN (forwarding outputs on the interface).
module mem_write_back_latch
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic CLK,
  input logic RST,
  mem_write_back_latch_if.slave bus
);
  if (DATA_W != WORD_W || REG_AW != REG_W) begin : g_width_check
    $error("mem_write_back_latch: DATA_W/REG_AW must match cpu_types_pkg widths");
  end
  memwb_t wb, nextWb;
  word_t memData;
  logic loadEn;
  mem_access_fsm u_fsm (
    .CLK(CLK),
    .RST(RST),
    .en(bus.en),
    .dREN(bus.in_dREN),
    .dWEN(bus.in_dWEN),
    .dhit(bus.dhit),
    .dmemload(bus.dmemload),
    .dmemREN(bus.dmemREN),
    .dmemWEN(bus.dmemWEN),
    .mem_stall(bus.mem_stall),
    .memData(memData)
`ifdef MEM_WB_FWD_EN
    ,
    .regWr(bus.in_regWr),
    .regDst(bus.in_regDst),
    .fwd_mem_valid(bus.fwd_mem_valid),
    .fwd_mem_reg(bus.fwd_mem_reg),
    .fwd_mem_data(bus.fwd_mem_data)
`endif
  );
  // a flush bubble may enter even while the access is still outstanding
  assign loadEn = bus.en && (bus.flush || !bus.mem_stall);
  always_comb begin
    nextWb.regWr = bus.flush ? 1'b0 : bus.in_regWr;
    nextWb.regDst = bus.flush ? '0 : bus.in_regDst;
    nextWb.regSel = bus.flush ? SEL_ALU : bus.in_regSel;
    nextWb.dmemload = (bus.flush || !bus.in_dREN || bus.in_dWEN) ? '0 : memData;
    nextWb.nPC = bus.flush ? '0 : bus.in_nPC;
    nextWb.ALUOut = bus.flush ? '0 : bus.in_ALUOut;
  end
  always_ff @(posedge CLK) begin
    if (RST) wb <= '0;
    else if (loadEn) wb <= nextWb;
  end
  assign bus.dmemaddr = bus.in_ALUOut;
  assign bus.dmemstore = bus.in_rdat2;
  assign bus.regWr = wb.regWr;
  assign bus.regDst = wb.regDst;
  assign bus.regSel = wb.regSel;
  assign bus.dmemload_q = wb.dmemload;
  assign bus.nPC = wb.nPC;
  assign bus.ALUOut = wb.ALUOut;
  assign bus.wdat = wb.regSel == SEL_MEM ? wb.dmemload : wb.regSel == SEL_NPC ? wb.nPC : wb.ALUOut;
`ifdef MEM_WB_FWD_EN
  assign bus.fwd_valid = wb.regWr && wb.regDst != '0;
  assign bus.fwd_reg = wb.regDst;
  assign bus.fwd_data = bus.wdat;
`endif
endmodule

// File: tb/tb_mem_write_back_latch.sv
// tb_mem_write_back_latch: directed self-checking bench for the MEM/WB stage
module tb_mem_write_back_latch;
  import cpu_types_pkg::*;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int tests = 0;
  int fails = 0;
  int cnt;
  mem_write_back_latch_if bus();
  mem_write_back_latch #(.DATA_W(32), .REG_AW(5)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle_inputs();
    bus.en = 0; bus.flush = 0; bus.in_regWr = 0; bus.in_dREN = 0; bus.in_dWEN = 0;
    bus.in_regDst = '0; bus.in_regSel = SEL_ALU; bus.in_ALUOut = '0; bus.in_rdat2 = '0;
    bus.in_nPC = '0; bus.dhit = 0; bus.dmemload = '0;
  endtask
  initial begin
    idle_inputs();
    tick(); tick();
    RST = 0;
    #1;
    chk("rst_regWr", 32'(bus.regWr), 0);
    chk("rst_wdat", bus.wdat, 0);
    chk("rst_dmemREN", 32'(bus.dmemREN), 0);
    chk("rst_stall", 32'(bus.mem_stall), 0);
    // 1: ALU op
    bus.in_ALUOut = 32'h1234; bus.in_regDst = 5; bus.in_regWr = 1; bus.in_regSel = SEL_ALU;
    bus.in_nPC = 32'h104; bus.en = 1;
    #1 chk("alu_stall", 32'(bus.mem_stall), 0);
    tick();
    chk("alu_regWr", 32'(bus.regWr), 1);
    chk("alu_regDst", 32'(bus.regDst), 5);
    chk("alu_wdat", bus.wdat, 32'h1234);
    // 2: load missing for 3 cycles
    bus.en = 0; bus.in_dREN = 1; bus.in_ALUOut = 32'h80; bus.in_regDst = 7; bus.in_regSel = SEL_MEM;
    #1 chk("ld_REN", 32'(bus.dmemREN), 1);
    chk("ld_addr", bus.dmemaddr, 32'h80);
    cnt = 0;
    repeat (3) begin
      if (bus.mem_stall) cnt++;
      tick();
    end
    chk("ld_hold_wdat", bus.wdat, 32'h1234);
    bus.dhit = 1; bus.dmemload = 32'hDEADBEEF; bus.en = 1;
    #1 chk("ld_hit_stall", 32'(bus.mem_stall), 0);
    tick();
    chk("ld_stall_cycles", cnt, 3);
    chk("ld_wdat", bus.wdat, 32'hDEADBEEF);
    chk("ld_dmemload_q", bus.dmemload_q, 32'hDEADBEEF);
    // 3: load hit while frozen, bus changes before release
    bus.en = 0; bus.in_ALUOut = 32'h90; bus.in_regDst = 9; bus.dmemload = 32'h11112222; bus.dhit = 1;
    #1 chk("frz_REN", 32'(bus.dmemREN), 1);
    chk("frz_stall", 32'(bus.mem_stall), 0);
    tick();
    bus.dhit = 0; bus.dmemload = 32'h99999999;
    #1 chk("done_REN", 32'(bus.dmemREN), 0);
    chk("done_stall", 32'(bus.mem_stall), 0);
    tick();
    chk("done_REN2", 32'(bus.dmemREN), 0);
    bus.en = 1;
    tick();
    chk("frz_wdat", bus.wdat, 32'h11112222);
    chk("frz_regDst", 32'(bus.regDst), 9);
    // 4: store hit while frozen issues exactly once
    bus.en = 0; bus.in_dREN = 0; bus.in_dWEN = 1; bus.in_regWr = 0; bus.in_regSel = SEL_ALU;
    bus.in_ALUOut = 32'h40; bus.in_rdat2 = 32'hCAFE; bus.dhit = 1;
    #1 chk("st_addr", bus.dmemaddr, 32'h40);
    chk("st_data", bus.dmemstore, 32'hCAFE);
    cnt = 0;
    repeat (4) begin
      if (bus.dmemWEN && bus.dhit) cnt++;
      tick();
    end
    chk("st_once", cnt, 1);
    bus.en = 1;
    tick();
    chk("st_regWr", 32'(bus.regWr), 0);
    chk("st_stall", 32'(bus.mem_stall), 0);
    // illegal load+store behaves as a store
    bus.en = 0; bus.in_dREN = 1; bus.dhit = 0;
    #1 chk("ill_REN", 32'(bus.dmemREN), 0);
    chk("ill_WEN", 32'(bus.dmemWEN), 1);
    bus.in_dREN = 0; bus.in_dWEN = 0;
    #1;
    // 5: flush
    bus.in_regWr = 1; bus.in_regDst = 3; bus.in_ALUOut = 32'h55; bus.en = 1;
    tick();
    chk("fl_pre_wdat", bus.wdat, 32'h55);
    bus.en = 0; bus.flush = 1; bus.in_ALUOut = 32'h77;
    tick();
    chk("fl_noen_regWr", 32'(bus.regWr), 1);
    chk("fl_noen_wdat", bus.wdat, 32'h55);
    bus.en = 1;
    tick();
    chk("fl_regWr", 32'(bus.regWr), 0);
    chk("fl_regDst", 32'(bus.regDst), 0);
    chk("fl_wdat", bus.wdat, 0);
    // 6: regDst 0 pass-through, then reset during WAIT
    bus.flush = 0; bus.in_regDst = 0; bus.in_regWr = 1; bus.in_ALUOut = 32'h66;
    tick();
    chk("r0_regWr", 32'(bus.regWr), 1);
    chk("r0_regDst", 32'(bus.regDst), 0);
`ifdef MEM_WB_FWD_EN
    chk("r0_fwd_valid", 32'(bus.fwd_valid), 0);
`endif
    bus.en = 0; bus.in_dREN = 1; bus.dhit = 0;
    tick();
    chk("w_stall", 32'(bus.mem_stall), 1);
    RST = 1;
    tick();
    chk("rw_REN", 32'(bus.dmemREN), 0);
    chk("rw_stall", 32'(bus.mem_stall), 0);
    chk("rw_regWr", 32'(bus.regWr), 0);
    RST = 0; bus.in_dREN = 0;
    tick();
    chk("rw_REN_after", 32'(bus.dmemREN), 0);
    chk("rw_stall_after", 32'(bus.mem_stall), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
